// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate test sequencers: state encoding and default
// stimulus constants.
package gate_test_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRIVE  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_NEXT   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_DRIVE  = ST_DRIVE,
    S_SETTLE = ST_SETTLE,
    S_CHECK  = ST_CHECK,
    S_NEXT   = ST_NEXT,
    S_DONE   = ST_DONE
  } state_e;

  localparam logic [31:0] DEF_PATTERN       = 32'h0000A5C3;
  localparam int          DEF_SETTLE_CYCLES = 2;

  // Index width for n entries, never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gate_test_sequencer_settle_timer.sv
// Loadable down-counter with a zero flag; counts stop at zero.
module settle_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_test_sequencer.sv
// Drives a single-bit gate through a fixed vector pattern, samples its output
// after a settle time and accumulates mismatches against the expected function.
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int          NUM_VEC       = 16,
  parameter logic [31:0] PATTERN       = DEF_PATTERN,
  parameter int          SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter bit          INVERT        = 1'b1,
  localparam int         ERR_W         = $clog2(NUM_VEC + 1),
  localparam int         IDX_W         = idx_width(NUM_VEC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_a,
  input  logic             dut_f,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [IDX_W-1:0] first_fail
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dut_a_q, dut_a_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [IDX_W-1:0] ff_q, ff_d;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [4:0]       pat_idx;

  assign pat_idx = 5'(idx_q);

  settle_timer #(.W(8)) u_timer (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (tmr_load),
    .dec_i      (tmr_dec),
    .load_val_i (8'(SETTLE_CYCLES - 1)),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dut_a_d  = dut_a_q;
    pass_d   = pass_q;
    err_d    = err_q;
    ff_d     = ff_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRIVE;
          idx_d   = '0;
          err_d   = '0;
          ff_d    = '0;
          pass_d  = 1'b0;
        end
      end
      S_DRIVE: begin
        dut_a_d  = PATTERN[pat_idx];
        tmr_load = 1'b1;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (tmr_zero) begin
          state_d = S_CHECK;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_CHECK: begin
        // dut_f is sampled raw: the gate shares this clock domain.
        if (dut_f != (dut_a_q ^ INVERT)) begin
          err_d = err_q + ERR_W'(1);
          if (err_q == '0) begin
            ff_d = idx_q;
          end
        end
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (idx_q == IDX_W'(NUM_VEC - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_DRIVE;
        end
      end
      S_DONE: begin
        pass_d  = (err_q == '0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      dut_a_q <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dut_a_q <= dut_a_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

  assign dut_a      = dut_a_q;
  assign busy       = (state_q == S_DRIVE) || (state_q == S_SETTLE) ||
                      (state_q == S_CHECK) || (state_q == S_NEXT);
  assign done       = (state_q == S_DONE);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer: gate models, vector table, random output
// stimulus against a timing-level reference model, and reset/start corners.
module tb_gate_test_sequencer;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  bit   rst_n = 1'b0;
  bit   start0 = 1'b0, start1 = 1'b0;
  logic f0, f1;
  logic a0, busy0, done0, pass0;
  logic a1, busy1, done1, pass1;
  logic [4:0] err0, err1;
  logic [3:0] ff0, ff1;

  int n_chk = 0;
  int n_fail = 0;

  bit [31:0] pat = 32'h0000A5C3;

  // Gate models: 0 inverter, 1 buffer, 2 stuck-0, 3 stuck-1, 4 random.
  int mode0 = 0;
  bit rnd = 1'b0;
  always_comb begin
    f0 = ~a0;
    case (mode0)
      1: f0 = a0;
      2: f0 = 1'b0;
      3: f0 = 1'b1;
      4: f0 = rnd;
      default: f0 = ~a0;
    endcase
  end

  // Inverter with one or two register stages of output delay.
  int mode1 = 1;
  bit dl1 = 1'b0, dl2 = 1'b0;
  always @(posedge clk) begin
    dl1 <= a1;
    dl2 <= dl1;
  end
  assign f1 = (mode1 == 2) ? ~dl2 : ~dl1;

  gate_test_sequencer u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .dut_a(a0), .dut_f(f0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_fail(ff0)
  );

  gate_test_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_a(a1), .dut_f(f1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_fail(ff1)
  );

  typedef struct {
    int mode;
    int exp_err;
    int exp_ff;
    int exp_pass;
  } vec_t;

  bit rec_f[0:299];
  bit rec_a[0:299];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Cycle 0 is the IDLE cycle whose closing edge samples start; lat returns
  // the cycle in which done is seen, or -1 when aborted by reset.
  task automatic run0(input int abort_at, input bit pulse, output int lat);
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    lat = 1;
    rnd = 1'($urandom);
    rec_f[1] = rnd;
    rec_a[1] = a0;
    while (!done0 && lat < 290) begin
      @(posedge clk); #1;
      lat++;
      if (lat == abort_at) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        lat = -1;
        return;
      end
      start0 = pulse && (lat == 10 || lat == 40);
      rnd = 1'($urandom);
      rec_f[lat] = rnd;
      rec_a[lat] = a0;
    end
    if (!done0) chk("run0_timeout", 0, 1);
  endtask

  task automatic run1(output int lat);
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    lat = 1;
    while (!done1 && lat < 290) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done1) chk("run1_timeout", 0, 1);
  endtask

  initial begin
    vec_t tbl[4];
    int lat, lat2, e_err, e_ff, prev;
    bit fk;

    tbl[0] = '{0, 0, 0, 1};
    tbl[1] = '{1, 16, 0, 0};
    tbl[2] = '{2, 8, 2, 0};
    tbl[3] = '{3, 8, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_dut_a", int'(a0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_pass", int'(pass0), 0);
    chk("rst_err", int'(err0), 0);
    chk("rst_ff", int'(ff0), 0);
    chk("rst1_busy", int'(busy1), 0);

    for (int i = 0; i < 4; i++) begin
      mode0 = tbl[i].mode;
      run0(-1, 1'b0, lat);
      chk($sformatf("tbl%0d_latency", i), lat, 81);
      chk($sformatf("tbl%0d_err", i), int'(err0), tbl[i].exp_err);
      if (tbl[i].exp_err != 0) chk($sformatf("tbl%0d_first_fail", i), int'(ff0), tbl[i].exp_ff);
      chk($sformatf("tbl%0d_busy_at_done", i), int'(busy0), 0);
      if (i == 0) begin
        for (int k = 0; k < 16; k++)
          chk($sformatf("dut_a_vec%0d", k), int'(rec_a[k * 5 + 4]), int'(pat[k]));
      end
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_pass", i), int'(pass0), tbl[i].exp_pass);
      chk($sformatf("tbl%0d_done_pulse", i), int'(done0), 0);
    end

    // Random gate output; the reference model looks at the sample cycle of
    // each vector, k*(S+3)+S+2, and expects the inverse of the pattern bit.
    mode0 = 4;
    for (int r = 0; r < 4; r++) begin
      run0(-1, 1'b0, lat);
      e_err = 0;
      e_ff = 0;
      for (int k = 0; k < 16; k++) begin
        fk = rec_f[k * 5 + 4];
        if (fk != ~pat[k]) begin
          if (e_err == 0) e_ff = k;
          e_err++;
        end
      end
      chk($sformatf("rand%0d_latency", r), lat, 81);
      chk($sformatf("rand%0d_err", r), int'(err0), e_err);
      if (e_err != 0) chk($sformatf("rand%0d_first_fail", r), int'(ff0), e_ff);
      @(posedge clk); #1;
      chk($sformatf("rand%0d_pass", r), int'(pass0), (e_err == 0) ? 1 : 0);
    end

    // Reset mid-run with errors already counted.
    mode0 = 1;
    run0(20, 1'b0, lat);
    chk("abort_returned", lat, -1);
    chk("abort_busy", int'(busy0), 0);
    chk("abort_err", int'(err0), 0);
    chk("abort_dut_a", int'(a0), 0);
    chk("abort_pass", int'(pass0), 0);
    chk("abort_ff", int'(ff0), 0);
    mode0 = 0;
    run0(-1, 1'b0, lat);
    chk("after_abort_latency", lat, 81);
    @(posedge clk); #1;
    chk("after_abort_pass", int'(pass0), 1);

    // Start pulses inside a run and during DONE are ignored.
    mode0 = 2;
    run0(-1, 1'b1, lat);
    chk("pulse_latency", lat, 81);
    chk("pulse_err", int'(err0), 8);
    chk("pulse_ff", int'(ff0), 2);
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    chk("start_in_done_busy", int'(busy0), 0);
    @(posedge clk); #1;
    chk("start_in_done_idle", int'(busy0), 0);
    chk("pulse_pass", int'(pass0), 0);

    // start held high: the IDLE cycle after done restarts the sequencer.
    mode0 = 0;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (!done0 && lat < 290) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("held_first_done", lat, 81);
    @(posedge clk); #1;
    lat++;
    chk("held_idle_gap_busy", int'(busy0), 0);
    chk("held_pass_run1", int'(pass0), 1);
    @(posedge clk); #1;
    lat++;
    chk("held_restart_busy", int'(busy0), 1);
    chk("held_restart_pass_cleared", int'(pass0), 0);
    while (!done0 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    start0 = 1'b0;
    chk("held_second_done", lat, 163);
    @(posedge clk); #1;
    chk("held_pass_run2", int'(pass0), 1);

    // SETTLE_CYCLES=1: a two-stage delayed gate samples the previous vector.
    mode1 = 2;
    prev = int'(a1);
    e_err = 0;
    for (int k = 0; k < 16; k++) begin
      if (int'(pat[k]) != prev) e_err++;
      prev = int'(pat[k]);
    end
    run1(lat2);
    chk("delay2_latency", lat2, 65);
    chk("delay2_err", int'(err1), e_err);
    chk("delay2_err_nonzero", (err1 != 0) ? 1 : 0, 1);
    @(posedge clk); #1;
    chk("delay2_pass", int'(pass1), 0);

    mode1 = 1;
    run1(lat2);
    chk("delay1_latency", lat2, 65);
    chk("delay1_err", int'(err1), 0);
    @(posedge clk); #1;
    chk("delay1_pass", int'(pass1), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
